// File: rtl/spi_pkt_rx.sv
// rtl/spi_pkt_rx.sv - SPI slave receiver that packs serial bits into words and buffers them.
// Define SPI_PKT_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register is used.
module spi_pkt_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int MSB_FIRST   = 1,
    parameter int SAMPLE_RISE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             byte_flg,
    output logic             frame_active,
    output logic [7:0]       word_cnt,
    output logic             overflow,
    output logic             frag_err,
    input  logic             clr_err
);
    localparam int   CW        = $clog2(WIDTH);
    localparam logic SCLK_IDLE = (SAMPLE_RISE != 0) ? 1'b0 : 1'b1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0]       sclk_sync_q, cs_sync_q;
    logic [1:0]       mosi_sync_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic             byte_flg_q, overflow_q, frag_err_q;
    logic             sclk_rise, sclk_fall, cs_rise, cs_fall, strobe;
    logic             push, pop, full, frag_set;

    // Index 1 is the synchronized level, index 2 the previous one for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= {3{SCLK_IDLE}};
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign strobe    = ((SAMPLE_RISE != 0) ? sclk_rise : sclk_fall) && (state_q == ACTIVE);

    always_comb begin
        if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], mosi_sync_q[1]};
        else                shifted = {mosi_sync_q[1], shreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        word_cnt_d = word_cnt_q;
        push       = 1'b0;
        frag_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    word_cnt_d = 8'd0;
                end
            end
            ACTIVE: begin
                // A strobe coinciding with cs_n release is deliberately dropped.
                if (cs_rise) begin
                    state_d   = IDLE;
                    frag_set  = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else if (strobe) begin
                    shreg_d = shifted;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        push       = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = (word_cnt_q != 8'hFF) ? word_cnt_q + 8'd1 : word_cnt_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            word_cnt_q <= 8'd0;
            byte_flg_q <= 1'b0;
            overflow_q <= 1'b0;
            frag_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            word_cnt_q <= word_cnt_d;
            byte_flg_q <= push;
            overflow_q <= clr_err ? 1'b0 : (overflow_q | (push & full & ~pop));
            frag_err_q <= clr_err ? 1'b0 : (frag_err_q | frag_set);
        end
    end

`ifdef SPI_PKT_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rptr_q] : '0;
`else
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign full = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (push && (!valid_q || pop)) begin
            data_q  <= shifted;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
`endif

    assign byte_flg     = byte_flg_q;
    assign frame_active = (state_q == ACTIVE);
    assign word_cnt     = word_cnt_q;
    assign overflow     = overflow_q;
    assign frag_err     = frag_err_q;
endmodule

// File: tb/tb_spi_pkt_rx.sv
// tb/tb_spi_pkt_rx.sv - directed self-checking bench for spi_pkt_rx.
module tb_spi_pkt_rx;
    logic        clk = 1'b0;
    logic        rst, sclk, cs_n, mosi, out_ready, clr_err;
    logic [7:0]  out_data;
    logic        out_valid, byte_flg, frame_active, overflow, frag_err;
    logic [7:0]  word_cnt;
    logic        sclk2, cs2_n, mosi2, ready2, clr2;
    logic [11:0] out_data2;
    logic        valid2, flg2, active2, ovf2, frag2;
    logic [7:0]  word_cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] got_q[$];
    logic [31:0] got2_q[$];
    int valid_cycles = 0;
    int flg_cnt = 0;
    int flg_with_valid = 0;

    always #5 clk = ~clk;

    spi_pkt_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .byte_flg(byte_flg), .frame_active(frame_active), .word_cnt(word_cnt),
        .overflow(overflow), .frag_err(frag_err), .clr_err(clr_err)
    );

    spi_pkt_rx #(.WIDTH(12), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .sclk(sclk2), .cs_n(cs2_n), .mosi(mosi2),
        .out_data(out_data2), .out_valid(valid2), .out_ready(ready2),
        .byte_flg(flg2), .frame_active(active2), .word_cnt(word_cnt2),
        .overflow(ovf2), .frag_err(frag2), .clr_err(clr2)
    );

    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) got_q.push_back(32'(out_data));
        if (byte_flg) begin
            flg_cnt++;
            if (out_valid) flg_with_valid++;
        end
        if (valid2 && ready2) got2_q.push_back(32'(out_data2));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        valid_cycles   = 0;
        flg_cnt        = 0;
        flg_with_valid = 0;
    endtask

    task automatic send1(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic open1();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic close1();
        tick(8);
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        sclk2 = 1'b0; cs2_n = 1'b1; mosi2 = 1'b0; ready2 = 1'b1; clr2 = 1'b0;
        tick(4);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_flg", 32'(byte_flg), 0);
        chk("rst_active", 32'(frame_active), 0);
        chk("rst_wcnt", 32'(word_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_frag", 32'(frag_err), 0);
        rst = 1'b0;
        tick(4);

        // Single 0xA5 word, consumer always ready.
        clear_mon();
        open1();
        chk("a5_active", 32'(frame_active), 1);
        send1(32'hA5, 8);
        close1();
        chk("a5_count", got_q.size(), 1);
        chk("a5_data", got_at(0), 32'hA5);
        chk("a5_vcyc", valid_cycles, 1);
        chk("a5_flg", flg_cnt, 1);
        chk("a5_lat", flg_with_valid, 1);
        chk("a5_wcnt", 32'(word_cnt), 1);
        chk("a5_idle", 32'(frame_active), 0);
        chk("a5_frag", 32'(frag_err), 0);

        // Fragmented frame of 3 bits, then a clean 0x5A frame.
        clear_mon();
        open1();
        send1(32'b101, 3);
        close1();
        chk("frag_set", 32'(frag_err), 1);
        chk("frag_none", got_q.size(), 0);
        open1();
        send1(32'h5A, 8);
        close1();
        chk("frag_count", got_q.size(), 1);
        chk("frag_data", got_at(0), 32'h5A);
        chk("frag_wcnt", 32'(word_cnt), 1);
        chk("frag_sticky", 32'(frag_err), 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("frag_clr", 32'(frag_err), 0);

`ifdef SPI_PKT_RX_FIFO_EN
        // Five words into a 4-deep FIFO with the consumer stalled.
        clear_mon();
        out_ready = 1'b0;
        open1();
        for (int k = 1; k <= 5; k++) send1(32'(k), 8);
        close1();
        chk("fifo_head", 32'(out_data), 32'h01);
        chk("fifo_ovf", 32'(overflow), 1);
        chk("fifo_wcnt", 32'(word_cnt), 5);
        out_ready = 1'b1;
        tick(10);
        chk("fifo_count", got_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("fifo_pop", got_at(k), 32'(k + 1));
        chk("fifo_empty", 32'(out_valid), 0);
`else
        // Back-to-back words, ready high then ready low.
        clear_mon();
        open1();
        send1(32'h11, 8);
        send1(32'h22, 8);
        close1();
        chk("b2b_count", got_q.size(), 2);
        chk("b2b_d0", got_at(0), 32'h11);
        chk("b2b_d1", got_at(1), 32'h22);
        chk("b2b_ovf", 32'(overflow), 0);
        chk("b2b_wcnt", 32'(word_cnt), 2);
        clear_mon();
        out_ready = 1'b0;
        open1();
        send1(32'h11, 8);
        send1(32'h22, 8);
        close1();
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'h11);
        chk("hold_ovf", 32'(overflow), 1);
        chk("hold_flg", flg_cnt, 2);
        chk("hold_wcnt", 32'(word_cnt), 2);
        out_ready = 1'b1;
        tick(3);
        chk("hold_pop", got_at(0), 32'h11);
        chk("hold_empty", 32'(out_valid), 0);
`endif
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Reset mid-word with a word parked in the buffer.
        out_ready = 1'b0;
        open1();
        send1(32'h77, 8);
        send1(32'h1F, 5);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        cs_n = 1'b1;
        tick(2);
        chk("in_rst_valid", 32'(out_valid), 0);
        chk("in_rst_data", 32'(out_data), 0);
        chk("in_rst_wcnt", 32'(word_cnt), 0);
        chk("in_rst_active", 32'(frame_active), 0);
        chk("in_rst_frag", 32'(frag_err), 0);
        rst = 1'b0;
        tick(4);
        clear_mon();
        out_ready = 1'b1;
        open1();
        send1(32'hC3, 8);
        close1();
        chk("rst_c3_count", got_q.size(), 1);
        chk("rst_c3_data", got_at(0), 32'hC3);
        chk("rst_c3_frag", 32'(frag_err), 0);
        chk("rst_c3_wcnt", 32'(word_cnt), 1);

        // 12-bit LSB-first word on the second instance.
        cs2_n = 1'b0;
        tick(8);
        for (int i = 0; i < 12; i++) begin
            mosi2 = 1'((32'h3C7 >> i) & 32'h1);
            tick(4);
            sclk2 = 1'b1;
            tick(4);
            sclk2 = 1'b0;
        end
        tick(8);
        cs2_n = 1'b1;
        tick(8);
        chk("w12_count", got2_q.size(), 1);
        chk("w12_data", (got2_q.size() > 0) ? got2_q[0] : 32'hDEAD_BEEF, 32'h3C7);
        chk("w12_wcnt", 32'(word_cnt2), 1);
        chk("w12_frag", 32'(frag2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_pkt_rx.md
SPI_PKT_RX -- requirements
Module: spi_pkt_rx

Interface
REQ-001 Parameter WIDTH, default 8: bits per received word, legal range 4..32.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words, a power of 2 in 2..16; used only when SPI_PKT_RX_FIFO_EN is defined.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in out_data[WIDTH-1]; 0 = first serial bit lands in out_data[0].
REQ-004 Parameter SAMPLE_RISE, default 1: 1 = sample mosi on sclk rising edge; 0 = sample on falling edge.
REQ-005 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port sclk, input, 1: SPI serial clock, asynchronous to clk.
REQ-008 Port cs_n, input, 1: SPI chip select, active-low, asynchronous.
REQ-009 Port mosi, input, 1: SPI serial data, asynchronous.
REQ-010 Port out_data, output, WIDTH: head word of the output buffer.
REQ-011 Port out_valid, output, 1: out_data holds a valid word.
REQ-012 Port out_ready, input, 1: consumer accepts the word; a pop occurs when out_valid and out_ready are both high.
REQ-013 Port byte_flg, output, 1: one-clk pulse per completed word.
REQ-014 Port frame_active, output, 1: high while the FSM is in ACTIVE.
REQ-015 Port word_cnt, output, 8: number of completed words in the current frame, saturating.
REQ-016 Port overflow, output, 1: sticky flag; a word was dropped because the buffer was full.
REQ-017 Port frag_err, output, 1: sticky flag; cs_n deasserted mid-word.
REQ-018 Port clr_err, input, 1: synchronous clear of overflow and frag_err.

Function
REQ-019 sclk, cs_n and mosi each pass through a 2-flop synchronizer; sclk and cs_n each get a third flop for edge detection.
REQ-020 Sample strobe: a 1-clk pulse on the synchronized sclk edge selected by SAMPLE_RISE, qualified by frame_active.
REQ-021 FSM has two states, IDLE and ACTIVE.
REQ-022 IDLE -> ACTIVE on the synchronized cs_n falling edge; this transition clears the bit counter, the shift register and word_cnt.
REQ-023 ACTIVE -> IDLE on the synchronized cs_n rising edge.
REQ-024 Each sample strobe shifts the synchronized mosi into the shift register per MSB_FIRST and increments the bit counter, which is $clog2(WIDTH) bits wide.
REQ-025 On the strobe that captures bit WIDTH: the full word (including that bit) is pushed to the buffer in the same clk edge, byte_flg is high for the next cycle only, word_cnt increments (saturating at 255), and the bit counter wraps to 0.
REQ-026 out_valid rises in the cycle after a push into an empty buffer, so latency from the final sample strobe to out_valid is 1 clk.
REQ-027 Push while the buffer is full and no pop occurs in the same cycle: the word is dropped, overflow is set, and byte_flg and word_cnt still update.
REQ-028 Simultaneous push and pop on a full buffer: both succeed, occupancy is unchanged, overflow is not set.
REQ-029 Simultaneous pop and push on an empty buffer cannot occur, because out_valid is low.
REQ-030 cs_n rising edge with the bit counter non-zero: the partial word is discarded, frag_err is set, and the bit counter clears.
REQ-031 cs_n rising edge with the bit counter zero: no error.
REQ-032 A sample strobe in the same cycle as the cs_n rising edge is ignored.
REQ-033 The buffer contents are preserved across frame boundaries.
REQ-034 clr_err has priority over a simultaneous set of overflow or frag_err.

Reset
REQ-035 While rst is high: FSM = IDLE; out_data = 0, out_valid = 0, byte_flg = 0, frame_active = 0, word_cnt = 0, overflow = 0, frag_err = 0.
REQ-036 While rst is high: the buffer is emptied, the bit counter and shift register are 0, and the synchronizers load the idle levels (sclk = SAMPLE_RISE ? 0 : 1, cs_n = 1, mosi = 0).
REQ-037 rst asserted mid-word or mid-frame aborts it with no flag set; after rst releases, a new cs_n falling edge is required to start a frame.

Configuration
REQ-038 Macro SPI_PKT_RX_FIFO_EN defined: the buffer is a DEPTH-entry circular FIFO, and out_data shows the head entry combinationally from FIFO storage.
REQ-039 Macro SPI_PKT_RX_FIFO_EN undefined: the buffer is a single holding register (full = out_valid), and DEPTH is ignored.
REQ-040 Both builds shall satisfy REQ-025 through REQ-034.

Verification
REQ-041 Defaults, cs_n low, 8 bits 0xA5 MSB-first, out_ready = 1 -> out_data = 0xA5, out_valid for 1 clk, one byte_flg pulse, word_cnt = 1.
REQ-042 MSB_FIRST = 0, WIDTH = 12, serial stream 0x3C7 sent LSB-first -> out_data = 0x3C7, word_cnt = 1.
REQ-043 FIFO build, out_ready = 0, 5 words 0x01..0x05 -> 0x01..0x04 held, overflow = 1; then out_ready = 1 -> pops 0x01, 0x02, 0x03, 0x04, out_valid = 0.
REQ-044 cs_n deasserted after 3 bits, then a new frame with 0x5A -> frag_err = 1, only 0x5A delivered, word_cnt = 1.
REQ-045 Non-FIFO build, out_ready held high, back-to-back words 0x11, 0x22 -> both delivered, overflow = 0; repeat with out_ready = 0 -> 0x11 held, overflow = 1.
REQ-046 rst pulsed after 5 bits, then a full frame with 0xC3 -> all outputs at reset values during rst, only 0xC3 delivered, frag_err = 0.
